// File: rtl/pedagio_arbitro.sv
// pedagio_arbitro: round-robin arbiter sharing one toll accumulator/display
// datapath between N_LANES booths. Picks a requesting booth, latches and
// classifies its vehicle, issues one clean ready pulse for valid vehicles,
// then completes a 4-phase ack handshake. Refused vehicles are counted.
// Optional build macro: PEDAGIO_PRIO_EN makes booth 0 a priority lane.

module pedagio_arbitro #(
    parameter int N_LANES    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_LANES-1:0]     req,
    input  logic [2*N_LANES-1:0]   lane_eixos,
    input  logic [4*N_LANES-1:0]   lane_peso,
    output logic [N_LANES-1:0]     ack,
    output logic                   nack,
    output logic                   ready,
    output logic [1:0]             Eixos,
    output logic [3:0]             Peso,
    output logic                   busy,
    output logic [7:0]             err_cnt
);

    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        PULSE,
        GAP,
        ACK
    } state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        lane, lane_nxt;
    logic [LW-1:0]        ptr, ptr_nxt;
    logic [GW-1:0]        gap_cnt, gap_nxt;
    logic [1:0]           eixos_nxt;
    logic [3:0]           peso_nxt;
    logic [N_LANES-1:0]   ack_nxt;
    logic                 nack_nxt;
    logic                 ready_nxt;
    logic [7:0]           err_nxt;

    logic [1:0]           eix_arr  [N_LANES];
    logic [3:0]           peso_arr [N_LANES];
    logic                 win_found;
    logic                 win_prio;
    logic [LW-1:0]        win_idx;
    logic                 vehicle_valid;
    logic [N_LANES-1:0]   lane_onehot;

    // Split the packed booth buses into per-lane fields for indexed selection
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            eix_arr[i]  = lane_eixos[2*i +: 2];
            peso_arr[i] = lane_peso[4*i +: 4];
        end
    end

    // Winner search: first requesting lane above the pointer, wrapping around
    always_comb begin
        int            cand;
        logic [LW-1:0] cand_idx;
        win_found = 1'b0;
        win_prio  = 1'b0;
        win_idx   = ptr;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= N_LANES; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N_LANES) begin
                cand = cand - N_LANES;
            end
            cand_idx = LW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
`ifdef PEDAGIO_PRIO_EN
        if (req[0]) begin
            win_found = 1'b1;
            win_prio  = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    // Vehicle category check on the latched data and the granted lane's one-hot
    always_comb begin
        vehicle_valid = ((Peso <= 4'd7)  && (Eixos == 2'b00)) ||
                        ((Peso <= 4'd12) && (Eixos == 2'b01)) ||
                        ((Peso >  4'd12) && (Eixos >= 2'b10));
        lane_onehot   = {{(N_LANES-1){1'b0}}, 1'b1} << lane;
    end

    // Next-state and registered-output logic for the grant/charge/handshake FSM
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        ptr_nxt   = ptr;
        gap_nxt   = gap_cnt;
        eixos_nxt = Eixos;
        peso_nxt  = Peso;
        ack_nxt   = ack;
        nack_nxt  = nack;
        ready_nxt = 1'b0;
        err_nxt   = err_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    lane_nxt  = win_idx;
                    eixos_nxt = eix_arr[win_idx];
                    peso_nxt  = peso_arr[win_idx];
                    if (!win_prio) begin
                        ptr_nxt = win_idx;
                    end
                    state_nxt = CLASSIFY;
                end
            end
            CLASSIFY: begin
                if (vehicle_valid) begin
                    ready_nxt = 1'b1;
                    state_nxt = PULSE;
                end else begin
                    ack_nxt  = lane_onehot;
                    nack_nxt = 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_nxt = err_cnt + 8'd1;
                    end
                    state_nxt = ACK;
                end
            end
            PULSE: begin
                gap_nxt   = GW'(GAP_CYCLES - 1);
                state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    ack_nxt   = lane_onehot;
                    nack_nxt  = 1'b0;
                    state_nxt = ACK;
                end else begin
                    gap_nxt = gap_cnt - GW'(1);
                end
            end
            ACK: begin
                if (!req[lane]) begin
                    ack_nxt   = '0;
                    nack_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without charge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lane    <= '0;
            ptr     <= LW'(N_LANES - 1);
            gap_cnt <= '0;
            Eixos   <= 2'b00;
            Peso    <= 4'd0;
            ack     <= '0;
            nack    <= 1'b0;
            ready   <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            lane    <= lane_nxt;
            ptr     <= ptr_nxt;
            gap_cnt <= gap_nxt;
            Eixos   <= eixos_nxt;
            Peso    <= peso_nxt;
            ack     <= ack_nxt;
            nack    <= nack_nxt;
            ready   <= ready_nxt;
            err_cnt <= err_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pedagio_arbitro.sv
// tb_pedagio_arbitro: self-checking bench for pedagio_arbitro with a
// transaction-timeline reference model, directed scenarios and random booths.
// Honors PEDAGIO_PRIO_EN for the priority-lane scenario.

module tb_pedagio_arbitro;

    localparam int N   = 4;
    localparam int GAP = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [2*N-1:0] lane_eixos;
    logic [4*N-1:0] lane_peso;
    logic [N-1:0]   ack;
    logic           nack;
    logic           ready;
    logic [1:0]     Eixos;
    logic [3:0]     Peso;
    logic           busy;
    logic [7:0]     err_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model: cycles since grant, granted lane and its data
    int         m_t;
    int         m_lane;
    int         m_ptr;
    int         m_err;
    int         m_ack_start;
    int         m_charges = 0;
    int         m_grants  = 0;
    bit         m_valid;
    logic [1:0] m_e;
    logic [3:0] m_p;

    int obs_pulses = 0;
    bit random_mode = 1'b0;
    bit raise_en    = 1'b0;

    pedagio_arbitro #(.N_LANES(N), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lane_eixos (lane_eixos),
        .lane_peso  (lane_peso),
        .ack        (ack),
        .nack       (nack),
        .ready      (ready),
        .Eixos      (Eixos),
        .Peso       (Peso),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit isValid(input logic [1:0] e, input logic [3:0] p);
        return (e == 2'd0 && p <= 4'd7) || (e == 2'd1 && p <= 4'd12) ||
               (e >= 2'd2 && p > 4'd12);
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_t = -1; m_lane = 0; m_ptr = N - 1; m_err = 0;
        m_ack_start = 2; m_valid = 1'b0; m_e = 2'd0; m_p = 4'd0;
    endtask

    // advance the model across one rising edge using the inputs the DUT sampled
    task automatic modelUpdate();
        int win;
        if (!reset) begin
            modelReset();
        end else if (m_t < 0) begin
            if (req != '0) begin
                win = -1;
`ifdef PEDAGIO_PRIO_EN
                if (req[0]) win = 0;
`endif
                if (win < 0) begin
                    for (int off = 1; off <= N; off++) begin
                        if (win < 0 && req[(m_ptr + off) % N]) win = (m_ptr + off) % N;
                    end
                    m_ptr = win;
                end
                m_lane = win;
                m_e = lane_eixos[2*win +: 2];
                m_p = lane_peso[4*win +: 4];
                m_valid = isValid(m_e, m_p);
                m_ack_start = m_valid ? 3 + GAP : 2;
                m_t = 1;
                m_grants++;
            end
        end else if (m_t >= m_ack_start) begin
            if (!req[m_lane]) m_t = -1;
        end else begin
            m_t++;
            if (m_t == 2) begin
                if (m_valid) m_charges++;
                else if (m_err < 255) m_err++;
            end
        end
    endtask

    task automatic checkOutput();
        bit         in_ack;
        logic [N-1:0] e_ack;
        in_ack = (m_t >= 1) && (m_t >= m_ack_start);
        e_ack  = in_ack ? (N'(1) << m_lane) : '0;
        if (ready) obs_pulses++;
        checkVal("model ack",     ack,     e_ack);
        checkVal("model nack",    nack,    in_ack && !m_valid);
        checkVal("model ready",   ready,   m_valid && m_t == 2);
        checkVal("model busy",    busy,    m_t >= 1);
        checkVal("model Eixos",   Eixos,   m_e);
        checkVal("model Peso",    Peso,    m_p);
        checkVal("model err_cnt", err_cnt, m_err);
    endtask

    task automatic setLane(input int i, input logic [1:0] e, input logic [3:0] p);
        lane_eixos[2*i +: 2] = e;
        lane_peso[4*i +: 4]  = p;
    endtask

    task automatic randData(input int i);
        case ($urandom_range(0, 3))
            0: setLane(i, 2'd0, 4'($urandom_range(0, 7)));
            1: setLane(i, 2'd1, 4'($urandom_range(0, 12)));
            2: setLane(i, 2'($urandom_range(2, 3)), 4'($urandom_range(13, 15)));
            default: setLane(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        endcase
    endtask

    // random booth agents: raise with data, hold until ack, then drop
    task automatic applyStimulus();
        bit granted;
        for (int i = 0; i < N; i++) begin
            granted = (m_t >= 1) && (m_lane == i);
            if (req[i]) begin
                if (ack[i]) req[i] = 1'b0;
                else if (granted && $urandom_range(0, 7) == 0) req[i] = 1'b0;
                else if (granted && $urandom_range(0, 1) == 1) randData(i);
            end else if (!ack[i] && !granted && raise_en && $urandom_range(0, 3) == 0) begin
                randData(i);
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
        if (random_mode) applyStimulus();
    endtask

    task automatic doReset();
        random_mode = 1'b0;
        reset = 1'b0;
        req = '0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic serveAck(input logic [N-1:0] exp_ack, input int exp_charge, input string name);
        int start;
        int k;
        start = obs_pulses;
        k = 0;
        while (ack == '0 && k < 60) begin step(); k++; end
        if (ack == '0) checkVal({name, " ack timeout"}, 0, 1);
        else checkVal({name, " ack"}, ack, exp_ack);
        req = req & ~ack;
        k = 0;
        while (ack != '0 && k < 10) begin step(); k++; end
        checkVal({name, " ack release"}, ack, 0);
        checkVal({name, " charges"}, obs_pulses - start, exp_charge);
    endtask

    initial begin
        int k;
        int order [5] = '{0, 1, 2, 3, 0};
        reset = 1'b0;
        req = '0;
        lane_eixos = '0;
        lane_peso = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkVal("reset ack", ack, 0);
        checkVal("reset nack", nack, 0);
        checkVal("reset ready", ready, 0);
        checkVal("reset busy", busy, 0);
        checkVal("reset err_cnt", err_cnt, 0);
        checkVal("reset Eixos", Eixos, 0);
        checkVal("reset Peso", Peso, 0);
        reset = 1'b1;

        // single valid vehicle on lane 0: ready 2 cycles after req, ack at 3+GAP
        setLane(0, 2'd0, 4'd5);
        req = 4'b0001;
        step(); step();
        checkVal("t1 ready", ready, 1);
        checkVal("t1 Eixos", Eixos, 0);
        checkVal("t1 Peso", Peso, 5);
        step();
        checkVal("t1 ready low", ready, 0);
        step();
        checkVal("t1 ack early", ack, 0);
        step();
        checkVal("t1 ack", ack, 4'b0001);
        checkVal("t1 nack", nack, 0);
        req = '0;
        step();
        checkVal("t1 ack cleared", ack, 0);
        checkVal("t1 busy", busy, 0);

        // invalid vehicle on lane 1, then saturate the error counter
        setLane(1, 2'd1, 4'd13);
        req = 4'b0010;
        step(); step();
        checkVal("t2 ack", ack, 4'b0010);
        checkVal("t2 nack", nack, 1);
        checkVal("t2 err_cnt", err_cnt, 1);
        req = '0;
        step();
        repeat (299) begin
            req = 4'b0010;
            serveAck(4'b0010, 0, "t2 sat");
        end
        checkVal("t2 err saturated", err_cnt, 255);

        // all four lanes requesting: rotation 0,1,2,3,0
        doReset();
        for (int i = 0; i < N; i++) setLane(i, 2'd2, 4'd15);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            serveAck(N'(1) << order[j], 1, "t3 rotation");
            req = req | (N'(1) << order[j]);
        end
        req = '0;
        step();

        // single lane 2 requesting repeatedly
        doReset();
        setLane(2, 2'd1, 4'd10);
        repeat (5) begin
            req = 4'b0100;
            serveAck(4'b0100, 1, "t4 regrant");
        end

        // asynchronous reset in the middle of GAP
        doReset();
        setLane(2, 2'd0, 4'd3);
        req = 4'b0100;
        k = 0;
        while (m_t != 3 && k < 20) begin step(); k++; end
        checkVal("t5 reached gap", m_t, 3);
        reset = 1'b0;
        #1;
        checkVal("t5 async ack", ack, 0);
        checkVal("t5 async ready", ready, 0);
        checkVal("t5 async busy", busy, 0);
        checkVal("t5 async Eixos", Eixos, 0);
        checkVal("t5 async Peso", Peso, 0);
        step(); step();
        reset = 1'b1;
        serveAck(4'b0100, 1, "t5 after reset");

        // lane 0 rising during lane 1's GAP
        doReset();
        for (int i = 0; i < N; i++) setLane(i, 2'd2, 4'd15);
        req = 4'b1110;
        k = 0;
        while (m_t != 3 && k < 20) begin step(); k++; end
        checkVal("t6 lane1 granted", m_lane, 1);
        req[0] = 1'b1;
        serveAck(4'b0010, 0, "t6 lane1");
`ifdef PEDAGIO_PRIO_EN
        serveAck(4'b0001, 1, "t6 prio lane0");
        serveAck(4'b0100, 1, "t6 then lane2");
`else
        serveAck(4'b0100, 1, "t6 rr lane2");
`endif
        req = '0;
        k = 0;
        while (busy && k < 40) begin step(); k++; end

        // random booths
        doReset();
        k = m_grants;
        random_mode = 1'b1;
        raise_en = 1'b1;
        repeat (4000) step();
        raise_en = 1'b0;
        k = m_grants - k;
        begin
            int d;
            d = 0;
            while ((req != '0 || m_t >= 0) && d < 300) begin step(); d++; end
            checkVal("random drain", (req == '0 && m_t < 0) ? 1 : 0, 1);
        end
        random_mode = 1'b0;
        checkVal("random activity", (k > 100) ? 1 : 0, 1);
        checkVal("total charges", obs_pulses, m_charges);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
